// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: accepts a payload word, then emits sync marker 1011,
// the payload MSB first, and an optional idle gap. Every output is a flop.
module seq_frame_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              x,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [3:0] SYNC_PAT = 4'b1011;
    localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);
    localparam logic [5:0] PRE_LAST = 6'(DATA_W - 2);
    localparam logic [5:0] LAST_GAP = 6'(GAP - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                x_q, x_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;

    // Next-state values describe the cycle that begins at the coming edge,
    // so x/frame_done/ready/busy all come straight from flops.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        ready_d      = ready_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_done_q ? frame_cnt_q + 8'd1 : frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                x_d     = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (valid_in && ready_q) begin
                    state_d = ST_SYNC;
                    shift_d = data_in;
                    x_d     = SYNC_PAT[3];
                    cnt_d   = 6'd0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_SYNC: begin
                if (cnt_q == 6'd3) begin
                    state_d      = ST_DATA;
                    x_d          = shift_q[DATA_W-1];
                    shift_d      = shift_q << 1;
                    cnt_d        = 6'd0;
                    frame_done_d = (DATA_W == 1);
                end else begin
                    x_d   = SYNC_PAT[2'd2 - cnt_q[1:0]];
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    x_d   = 1'b0;
                    cnt_d = 6'd0;
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    x_d          = shift_q[DATA_W-1];
                    shift_d      = shift_q << 1;
                    cnt_d        = cnt_q + 6'd1;
                    frame_done_d = (cnt_q == PRE_LAST);
                end
            end
            ST_GAP: begin
                x_d = 1'b0;
                if (cnt_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = 1'b0;
            end
        endcase
    end

    // ready stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= 6'd0;
            x_q          <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign ready_out  = ready_q;
    assign busy       = busy_q;
    assign x          = x_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed/randomized bench for seq_frame_tx: one instance with DATA_W=8,GAP=1
// and one with DATA_W=1,GAP=0, checked cycle by cycle against frame bit lists.
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_x, a_busy, a_fd;
    logic [7:0] a_cnt_o;
    logic [0:0] b_data;
    logic       b_valid, b_ready, b_x, b_busy, b_fd;
    logic [7:0] b_cnt_o;

    int errors = 0;
    int checks = 0;
    int a_cnt  = 0;
    int b_cnt  = 0;

    always #5 clk = ~clk;

    seq_frame_tx #(.DATA_W(8), .GAP(1)) dut_a (
        .clk(clk), .reset(rst_n), .data_in(a_data), .valid_in(a_valid),
        .ready_out(a_ready), .x(a_x), .busy(a_busy), .frame_done(a_fd),
        .frame_cnt(a_cnt_o)
    );

    seq_frame_tx #(.DATA_W(1), .GAP(0)) dut_b (
        .clk(clk), .reset(rst_n), .data_in(b_data), .valid_in(b_valid),
        .ready_out(b_ready), .x(b_x), .busy(b_busy), .frame_done(b_fd),
        .frame_cnt(b_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge after the gap.
    task automatic run_frame_a(input logic [7:0] d, input bit hold);
        logic [11:0] seq;
        int          exp_cnt;
        seq = {4'b1011, d};
        chk("a_ready_pre", 32'(a_ready), 32'd1);
        chk("a_busy_pre", 32'(a_busy), 32'd0);
        a_valid = 1'b1;
        a_data  = d;
        @(negedge clk);
        if (!hold) a_valid = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            a_data  = 8'($urandom);
            exp_cnt = (k <= 12) ? a_cnt : (a_cnt + 1) % 256;
            chk($sformatf("a_x[%0d]", k), 32'(a_x), (k <= 12) ? 32'(seq[12-k]) : 32'd0);
            chk($sformatf("a_fd[%0d]", k), 32'(a_fd), (k == 12) ? 32'd1 : 32'd0);
            chk($sformatf("a_busy[%0d]", k), 32'(a_busy), 32'd1);
            chk($sformatf("a_ready[%0d]", k), 32'(a_ready), 32'd0);
            chk($sformatf("a_cnt[%0d]", k), 32'(a_cnt_o), 32'(exp_cnt));
            @(negedge clk);
        end
        a_cnt = (a_cnt + 1) % 256;
        chk("a_cnt_post", 32'(a_cnt_o), 32'(a_cnt));
        $display("frame A data=%02h cnt=%0d", d, a_cnt);
    endtask

    task automatic run_frame_b(input logic d, input bit hold);
        logic [4:0] seq;
        seq = {4'b1011, d};
        chk("b_ready_pre", 32'(b_ready), 32'd1);
        b_valid   = 1'b1;
        b_data[0] = d;
        @(negedge clk);
        if (!hold) b_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            b_data[0] = 1'($urandom);
            chk($sformatf("b_x[%0d]", k), 32'(b_x), 32'(seq[5-k]));
            chk($sformatf("b_fd[%0d]", k), 32'(b_fd), (k == 5) ? 32'd1 : 32'd0);
            chk($sformatf("b_busy[%0d]", k), 32'(b_busy), 32'd1);
            chk($sformatf("b_cnt[%0d]", k), 32'(b_cnt_o), 32'(b_cnt));
            @(negedge clk);
        end
        b_cnt = (b_cnt + 1) % 256;
        chk("b_cnt_post", 32'(b_cnt_o), 32'(b_cnt));
        chk("b_ready_post", 32'(b_ready), 32'd1);
        $display("frame B data=%0d cnt=%0d", d, b_cnt);
    endtask

    initial begin
        logic [7:0] d;
        a_valid = 1'b0; a_data = 8'h00;
        b_valid = 1'b0; b_data = 1'b0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_x", 32'(a_x), 32'd0);
        chk("rst_fd", 32'(a_fd), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_cnt", 32'(a_cnt_o), 32'd0);
        @(negedge clk);
        chk("rst_ready_clk", 32'(a_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("idle_x", 32'(a_x), 32'd0);
            chk("idle_ready", 32'(a_ready), 32'd1);
            chk("idle_busy", 32'(a_busy), 32'd0);
            @(negedge clk);
        end
        $display("idle 20 cycles done");

        run_frame_a(8'hA5, 1'b0);
        chk("a5_ready_after_gap", 32'(a_ready), 32'd1);

        run_frame_a(8'h00, 1'b1);
        run_frame_a(8'hFF, 1'b0);

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            run_frame_a(d, 1'($urandom_range(0, 1)));
        end
        a_valid = 1'b0;
        repeat (2) @(negedge clk);

        run_frame_b(1'b1, 1'b0);
        run_frame_b(1'b0, 1'b1);
        run_frame_b(1'b1, 1'b0);

        // Mid-frame reset at cycle 7, between clock edges.
        d = 8'($urandom);
        a_valid = 1'b1; a_data = d;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_x_c7", 32'(a_x), 32'(d[7-2]));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_x", 32'(a_x), 32'd0);
        chk("mid_rst_cnt", 32'(a_cnt_o), 32'd0);
        chk("mid_rst_fd", 32'(a_fd), 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        a_cnt = 0; b_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_hold_fd", 32'(a_fd), 32'd0);
            chk("mid_hold_cnt", 32'(a_cnt_o), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("mid-frame reset released");
        run_frame_a(8'($urandom), 1'b0);

        // Clean count, then 256 back-to-back frames to wrap 255 -> 0.
        @(negedge clk);
        rst_n = 1'b0;
        a_cnt = 0; b_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            run_frame_a(8'($urandom), (i != 255));
        end
        chk("wrap_cnt_zero", 32'(a_cnt_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  DATA_W   8   payload width in bits; legal range 1..32.
  GAP      1   idle cycles forced after each frame; legal range 0..15.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
  clk        in   1       single clock; all state changes on its rising edge.
  reset      in   1       asynchronous, active-low reset (0 = reset asserted).
  data_in    in   DATA_W  payload word; sampled only on acceptance.
  valid_in   in   1       payload word offered.
  ready_out  out  1       block can accept a word this cycle.
  x          out  1       registered serial output bit stream.
  busy       out  1       high while a frame or gap is in progress.
  frame_done out  1       one-cycle pulse marking the last payload bit on x.
  frame_cnt  out  8       count of completed frames, modulo 256.

Function
REQ-003 A frame SHALL be the 4-bit sync marker 1,0,1,1 followed by the DATA_W payload bits, MSB first.
REQ-004 The FSM SHALL have exactly four states: IDLE, SYNC, DATA and GAP.
REQ-005 ready_out SHALL be 1 only in IDLE; busy SHALL be the inverse of ready_out.
REQ-006 Acceptance SHALL occur at a rising edge where valid_in=1 and ready_out=1.
  - data_in is captured into a shift register at that edge.
  - The state moves IDLE->SYNC at that edge.
REQ-007 In IDLE, x SHALL be 0 and valid_in=0 SHALL keep the FSM in IDLE.
REQ-008 In SYNC, x SHALL be driven from a registered source (no combinational path from any input).
  - x = 1,0,1,1 on the 1st..4th cycles after acceptance.
  - SYNC->DATA after the 4th sync cycle.
REQ-009 In DATA, x SHALL carry captured bit DATA_W-1 down to bit 0, one bit per cycle, for DATA_W cycles.
REQ-010 frame_done SHALL be 1 exactly during the cycle in which payload bit 0 is on x, and 0 otherwise.
REQ-011 frame_cnt SHALL increment by 1 at the clock edge that ends the frame_done cycle, wrapping 255->0.
REQ-012 After DATA, the FSM SHALL enter GAP for GAP cycles with x=0, then return to IDLE.
  - With GAP=0, the FSM SHALL go DATA->IDLE directly.
REQ-013 The minimum accept-to-accept spacing SHALL be 4+DATA_W+GAP+1 cycles, because acceptance is possible only in IDLE.
REQ-014 valid_in and data_in SHALL be ignored while busy=1.
  - Changes to data_in after acceptance SHALL NOT alter the frame in flight.
REQ-015 The frame SHALL be transmitted whole once accepted; there is no abort input.
REQ-016 With DATA_W=1, the DATA state SHALL last exactly one cycle, and frame_done SHALL coincide with that cycle.

Reset
REQ-017 While reset=0, the block SHALL immediately (asynchronously) force the following.
  - state=IDLE.
  - x=0, frame_done=0, busy=0, frame_cnt=0, shift register=0.
  - ready_out SHALL be 1 only after reset is deasserted.
REQ-018 Reset asserted mid-frame SHALL discard the frame.
  - No frame_done pulse is produced.
  - frame_cnt is not incremented.
  - After release, the first acceptance starts a fresh frame with the sync marker.

Verification
REQ-019 The bench SHALL cover the following scenarios (stimulus -> required response).
  - DATA_W=8, GAP=1, accept 8'hA5 -> x over 12 cycles = 1011 10100101; frame_done on cycle 12; frame_cnt=1; one x=0 gap cycle; ready_out=1 on the cycle after the gap.
  - valid_in held high continuously, words 8'h00 then 8'hFF -> frames start 14 cycles apart; second payload = eight 1s; data_in changes during frame 1 have no effect.
  - GAP=0, DATA_W=1, accept 1'b1 -> x = 1,0,1,1,1; frame_done on cycle 5; ready_out=1 on cycle 6.
  - reset driven low at cycle 7 of a frame -> x=0 and frame_cnt=0 immediately without waiting for clk; no frame_done; the next frame after release starts with 1011.
  - 256 back-to-back frames -> frame_cnt wraps from 255 to 0 on the 256th frame_done.
  - valid_in=0 for 20 cycles after reset -> x=0, ready_out=1, busy=0 throughout.
